// File: rtl/demux_pkg.sv
// Shared types and constants for the 4-way demux serial feeder.
package demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

  // Width of a counter that must index n positions (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux4_serial_tx_if.sv
// Producer handshake plus the serial/select outputs toward the demux.
interface demux4_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_ch;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       A;
  logic             din;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_ch, in_data,
    input  in_ready, A, din, busy, done
  );

  modport slave (
    input  in_valid, in_ch, in_data,
    output in_ready, A, din, busy, done
  );
endinterface

// File: rtl/piso_shift.sv
// Parallel-load, MSB-first shift register; zeros are shifted in at the LSB
// so the serial output settles to 0 once the word has been fully emitted.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] par_in,
  output logic             sout
);

  logic [WIDTH-1:0] sr_q;

  // Load wins over shift; the MSB is the bit currently on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= par_in;
    end else if (shift) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign sout = sr_q[WIDTH-1];

endmodule

// File: rtl/demux4_serial_tx.sv
// Serializes accepted words MSB-first onto din while holding the demux
// select A steady for the whole frame, followed by a programmable idle gap.
module demux4_serial_tx
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input logic               clk,
  input logic               rst_n,
  demux4_serial_tx_if.slave bus
);

  localparam int             CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  BIT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;

  logic [1:0]    a_q, a_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rdy_q, rdy_d;
  logic          sout;
  logic          accept;

  // Handshake only completes from IDLE while in_ready is already presented.
  assign accept = (state_q == ST_IDLE) && bus.in_valid && rdy_q;

  piso_shift #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .shift  (state_q == ST_SHIFT),
    .par_in (bus.in_data),
    .sout   (sout)
  );

  // State and counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Next-state and counter update; counters stop at their terminal value.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          if (GAP > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    a_d    = accept ? bus.in_ch : a_q;
    busy_d = (state_d != ST_IDLE);
    rdy_d  = (state_d == ST_IDLE);
    done_d = (state_d == ST_SHIFT) && (bit_cnt_d == BIT_LAST);
  end

  // Output register; A only moves on acceptance, never inside a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= CH0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rdy_q  <= rdy_d;
    end
  end

  assign bus.A        = a_q;
  assign bus.din      = sout;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.in_ready = rdy_q;

endmodule
